// File: rtl/bcd_7seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_7seg_scan
//   Time-multiplexed driver for a multi-digit 7-segment display. NUM_DIGITS
//   packed BCD digits share one segment bus. Each digit gets its own anode
//   enable and is lit in turn for REFRESH_DIV enabled clocks.
//
//   Data path: bcd_in/dp_in -> hold bank (on load) -> active bank (on frame
//   wrap) -> decode/blank -> registered seg/dp/an. Because the active bank
//   only changes on the wrap cycle, a frame always shows one consistent value.
//
// Ports
//   clk        : single clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : scanning enable; prescaler and digit index freeze when low
//   load       : one-cycle strobe capturing bcd_in / dp_in into the hold bank
//   bcd_in     : packed BCD, digit k at [4k+3:4k], digit 0 least significant
//   dp_in      : decimal point per digit
//   blank_lz   : enables leading-zero blanking
//   seg        : segments {a,b,c,d,e,f,g}, seg[6]=a, polarity SEG_ACTIVE_LOW
//   dp         : decimal point of the lit digit, polarity SEG_ACTIVE_LOW
//   an         : one-hot digit enable, polarity AN_ACTIVE_LOW
//   digit_idx  : digit currently being addressed (scan state)
//   frame_done : one-cycle pulse on the frame-wrap cycle
// ---------------------------------------------------------------------------
module bcd_7seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDXW-1:0]         digit_idx,
  output logic                    frame_done
);

  localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IDXW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_hold_bcd;
  logic [NUM_DIGITS-1:0]   r_hold_dp;
  logic [4*NUM_DIGITS-1:0] r_act_bcd;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                  w_tc;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [3:0]            w_code;
  logic                  w_dp_cur;
  logic                  w_blank_cur;

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    case (code)
      4'd0:    f_decode = 7'b1111110;
      4'd1:    f_decode = 7'b0110000;
      4'd2:    f_decode = 7'b1101101;
      4'd3:    f_decode = 7'b1111001;
      4'd4:    f_decode = 7'b0110011;
      4'd5:    f_decode = 7'b1011011;
      4'd6:    f_decode = 7'b1011111;
      4'd7:    f_decode = 7'b1110000;
      4'd8:    f_decode = 7'b1111111;
      4'd9:    f_decode = 7'b1111011;
      default: f_decode = 7'b0000000;
    endcase
  endfunction

  assign w_tc   = enable && (r_presc == PRESC_LAST);
  assign w_wrap = w_tc && (r_idx == IDX_LAST);

  // w_lead_zero[k] is set when digit k and every more-significant digit are
  // code 0. Codes 10..15 break the run because they compare non-zero.
  always_comb begin : lead_zero_scan
    logic v_zero;
    v_zero      = 1'b1;
    w_lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_zero         = v_zero && (r_act_bcd[4*k +: 4] == 4'd0);
      w_lead_zero[k] = v_zero;
    end
  end

  // Select the addressed digit from the active bank. Digit 0 is never blanked.
  always_comb begin
    w_code      = 4'd0;
    w_dp_cur    = 1'b0;
    w_blank_cur = 1'b0;
    w_onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_onehot[k] = 1'b1;
        w_code      = r_act_bcd[4*k +: 4];
        w_dp_cur    = r_act_dp[k];
        w_blank_cur = blank_lz && (k != 0) && w_lead_zero[k];
      end
    end
  end

  // Refresh prescaler and digit index; both freeze while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (enable) begin
      if (w_tc) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Hold bank takes every load. Active bank changes only on the wrap cycle;
  // a load landing on that same cycle bypasses the hold bank so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_bcd <= '0;
      r_hold_dp  <= '0;
      r_act_bcd  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (load) begin
        r_hold_bcd <= bcd_in;
        r_hold_dp  <= dp_in;
      end
      if (w_wrap) begin
        r_act_bcd <= load ? bcd_in : r_hold_bcd;
        r_act_dp  <= load ? dp_in  : r_hold_dp;
      end
    end
  end

  // Registered, active-high display outputs, all updated on the same edge so
  // anode and segment changes never straddle two digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '0;
      r_seg <= '0;
      r_dp  <= 1'b0;
    end else if (enable) begin
      r_an  <= w_onehot;
      r_seg <= w_blank_cur ? 7'b0000000 : f_decode(w_code);
      r_dp  <= w_dp_cur;
    end else begin
      r_an  <= '0;
      r_seg <= '0;
      r_dp  <= 1'b0;
    end
  end

  // Pin polarity is a constant inversion after the registers, so reset still
  // drives every output to its inactive level without a clock.
  assign an         = AN_ACTIVE_LOW  ? ~r_an  : r_an;
  assign seg        = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign dp         = SEG_ACTIVE_LOW ? ~r_dp  : r_dp;
  assign digit_idx  = r_idx;
  assign frame_done = w_wrap && rst_n;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_7seg_scan
//   Two instances share every input: dut_a uses default polarity
//   (active-high segments, active-low anodes), dut_b the opposite polarity.
//   A frame-position model (one counter over NUM_DIGITS*REFRESH_DIV enabled
//   cycles, digit = position / REFRESH_DIV) predicts every output; each cycle
//   the prediction is queued in exp_q and popped by the running test.
// ---------------------------------------------------------------------------
module tb_bcd_7seg_scan;
  localparam int N     = 4;
  localparam int R     = 4;
  localparam int FRAME = N * R;
  localparam int W     = 27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   bcd_in = '0;
  logic [3:0]    dp_in = '0;
  logic          blank_lz = 1'b0;

  logic [6:0] a_seg, b_seg;
  logic       a_dp, b_dp;
  logic [3:0] a_an, b_an;
  logic [1:0] a_idx, b_idx;
  logic       a_fd, b_fd;

  bcd_7seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(a_seg), .dp(a_dp), .an(a_an),
    .digit_idx(a_idx), .frame_done(a_fd)
  );

  bcd_7seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(b_seg), .dp(b_dp), .an(b_an),
    .digit_idx(b_idx), .frame_done(b_fd)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  int          m_pos = 0;
  logic [15:0] m_hold = '0;
  logic [15:0] m_act = '0;
  logic [3:0]  m_hold_dp = '0;
  logic [3:0]  m_act_dp = '0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_v;
  logic [W-1:0] e;
  int total = 0;
  int bad = 0;

  function automatic logic [6:0] ref_seg(input logic [15:0] val, input int d, input logic blz);
    int msd;
    msd = -1;
    for (int k = 0; k < N; k++)
      if (val[4*k +: 4] != 4'd0) msd = k;
    if (blz && d > 0 && d > msd) return 7'b0000000;
    return seg_tab[val[4*d +: 4]];
  endfunction

  task automatic model_reset();
    m_pos = 0; m_hold = '0; m_act = '0; m_hold_dp = '0; m_act_dp = '0;
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic tick();
    logic       fd_exp, fd_obs, edp;
    logic [3:0] ea;
    logic [6:0] es;
    logic [1:0] eidx;
    int d;
    #1;
    fd_obs = a_fd;
    fd_exp = enable && (m_pos == FRAME - 1);
    @(posedge clk);
    if (enable) begin
      d   = m_pos / R;
      ea  = 4'(1 << d);
      es  = ref_seg(m_act, d, blank_lz);
      edp = m_act_dp[d];
      if (m_pos == FRAME - 1) begin
        m_act    = load ? bcd_in : m_hold;
        m_act_dp = load ? dp_in : m_hold_dp;
      end
      m_pos = (m_pos + 1) % FRAME;
    end else begin
      ea = 4'b0000; es = 7'b0000000; edp = 1'b0;
    end
    if (load) begin
      m_hold    = bcd_in;
      m_hold_dp = dp_in;
    end
    eidx = 2'(m_pos / R);
    exp_q.push_back({~ea, es, edp, eidx, fd_exp, ea, ~es, ~edp});
    @(negedge clk);
    obs_v = {a_an, a_seg, a_dp, a_idx, fd_obs, b_an, b_seg, b_dp};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({a_an, a_seg, a_dp, a_idx, a_fd} !== {4'hF, 7'h00, 1'b0, 2'd0, 1'b0}) begin
      bad++; $display("FAIL reset_a got=%h exp=%h", {a_an, a_seg, a_dp, a_idx, a_fd}, {4'hF, 7'h00, 1'b0, 2'd0, 1'b0});
    end
    total++;
    if ({b_an, b_seg, b_dp} !== {4'h0, 7'h7F, 1'b1}) begin
      bad++; $display("FAIL reset_b got=%h exp=%h", {b_an, b_seg, b_dp}, {4'h0, 7'h7F, 1'b1});
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    blank_lz = 1'b0; enable = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000;
    for (int c = 0; c < 3 * FRAME; c++) begin
      load = (c == 0);
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL scan c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    load = 1'b0;
  endtask

  task automatic test_blank();
    blank_lz = 1'b1; enable = 1'b1; dp_in = 4'b0000;
    for (int c = 0; c < 5 * FRAME; c++) begin
      load   = (c == 0) || (c == 40);
      bcd_in = (c < 40) ? 16'h0050 : 16'h0000;
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL blank c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    load = 1'b0;
  endtask

  task automatic test_tear();
    int stage, c_mark;
    stage = 0; c_mark = 0;
    blank_lz = 1'b0; enable = 1'b1; dp_in = 4'b0000;
    for (int c = 0; c < 8 * FRAME; c++) begin
      load = 1'b0;
      if (c == 0) begin
        load = 1'b1; bcd_in = 16'h1234;
      end else if (stage == 0 && c >= 2 * FRAME && m_pos == 6) begin
        load = 1'b1; bcd_in = 16'h9999; stage = 1; c_mark = c;
      end else if (stage == 1 && c >= c_mark + FRAME + 2 && m_pos == FRAME - 1) begin
        load = 1'b1; bcd_in = 16'h5678; stage = 2;
      end
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL tear c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    load = 1'b0;
  endtask

  task automatic test_invalid_dp();
    blank_lz = 1'b1; enable = 1'b1; bcd_in = 16'h00A0; dp_in = 4'b0010;
    for (int c = 0; c < 3 * FRAME; c++) begin
      load = (c == 0);
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL invalid_dp c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    load = 1'b0;
  endtask

  task automatic test_polarity();
    blank_lz = 1'b0; enable = 1'b1; bcd_in = 16'h8888; dp_in = 4'b0101;
    for (int c = 0; c < 2 * FRAME + 3; c++) begin
      load = (c == 0);
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL polarity c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    load = 1'b0;
  endtask

  task automatic test_enable_reset();
    blank_lz = 1'b0; enable = 1'b1; load = 1'b0;
    // Park in the middle of digit 2, then stall.
    for (int c = 0; c < FRAME && m_pos != 9; c++) begin
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL en_run c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    for (int c = 0; c < FRAME + 10; c++) begin
      enable = !(c < 5);
      load   = (c == 2);
      bcd_in = 16'h4321;
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL en_stall c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    load = 1'b0; enable = 1'b1;
    // Asynchronous reset between clock edges, mid-frame.
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({a_an, a_seg, a_dp, a_idx, a_fd} !== {4'hF, 7'h00, 1'b0, 2'd0, 1'b0}) begin
      bad++; $display("FAIL async_rst_a got=%h exp=%h", {a_an, a_seg, a_dp, a_idx, a_fd}, {4'hF, 7'h00, 1'b0, 2'd0, 1'b0});
    end
    total++;
    if ({b_an, b_seg, b_dp} !== {4'h0, 7'h7F, 1'b1}) begin
      bad++; $display("FAIL async_rst_b got=%h exp=%h", {b_an, b_seg, b_dp}, {4'h0, 7'h7F, 1'b1});
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < FRAME + 2; c++) begin
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL post_rst c=%0d got=%h exp=%h", c, obs_v, e); end
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 5) == 0);
      bcd_in = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      tick();
      e = exp_q.pop_front(); total++;
      if (obs_v !== e) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_v, e); end
    end
    load = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_tear();
    test_invalid_dp();
    test_polarity();
    test_enable_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
